// File: rtl/y86_fetch_queue.sv
// y86_fetch_queue: byte-addressed program memory feeding a circular byte queue,
// with one length-decoded Y86 instruction presented at a time on valid/ready.
// Supports PC redirection and stops after a HALT instruction is accepted.
module y86_fetch_queue #(
   parameter int MEM_BYTES   = 128,
   parameter int FETCH_BYTES = 2,
   parameter int QUEUE_BYTES = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load_en,
   input  logic [63:0] load_addr,
   input  logic [7:0]  load_data,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [79:0] out_instr,
   output logic [63:0] out_pc,
   output logic [3:0]  out_len,
   output logic [1:0]  out_err,
   output logic        halted
);

   localparam int          AW      = $clog2(MEM_BYTES);
   localparam int          HW      = $clog2(QUEUE_BYTES);
   localparam int          CW      = $clog2(QUEUE_BYTES + 1);
   localparam int unsigned QB      = QUEUE_BYTES;
   localparam int unsigned FB      = FETCH_BYTES;
   localparam logic [63:0] MEM_END = 64'(MEM_BYTES);

   typedef enum logic {
      RUN,
      HALTED
   } state_t;

   state_t         state;
   state_t         state_next;

   logic [7:0]     mem  [MEM_BYTES];
   logic [7:0]     qbuf [QUEUE_BYTES];
   logic [HW-1:0]  head;
   logic [CW-1:0]  count;
   logic [63:0]    fetch_ptr;
   logic [63:0]    head_pc;

   logic [7:0]     win [10];
   logic [3:0]     icode;
   logic [3:0]     dec_len;
   logic           have_all;
   logic           at_end;
   logic           pop;
   logic           halt_pop;
   logic [CW-1:0]  pop_bytes;
   int unsigned    free_bytes;
   int unsigned    fill_n;
   logic [7:0]     fill_byte [FETCH_BYTES];

   // Queue slot index for a byte at offset 'off' from slot 'base', wrapping around the ring.
   function automatic logic [HW-1:0] qidx(input int unsigned base, input int unsigned off);
      return HW'((base + off) % QB);
   endfunction

   assign at_end = (fetch_ptr >= MEM_END);

   // Program memory write port; deliberately independent of reset so a program can be loaded while held in reset.
   always_ff @(posedge clk) begin
      if (load_en && (load_addr < MEM_END)) begin
         mem[load_addr[AW-1:0]] <= load_data;
      end
   end

   // State register: reset returns to RUN, otherwise follow the next-state logic.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= RUN;
      end else begin
         state <= state_next;
      end
   end

   // Next state: a redirect always restarts fetching, an accepted HALT stops it.
   always_comb begin
      state_next = state;
      if (redirect_valid) begin
         state_next = RUN;
      end else if ((state == RUN) && halt_pop) begin
         state_next = HALTED;
      end
   end

   // Output decode: window the head bytes, decode the length from the head icode and qualify validity.
   always_comb begin
      for (int k = 0; k < 10; k++) begin
         win[k] = (CW'(k) < count) ? qbuf[qidx(32'(head), k)] : 8'h00;
      end
      icode = win[0][7:4];
      case (icode)
         4'h0, 4'h1, 4'h9:       dec_len = 4'd1;
         4'h2, 4'h6, 4'hA, 4'hB: dec_len = 4'd2;
         4'h7, 4'h8:             dec_len = 4'd9;
         4'h3, 4'h4, 4'h5:       dec_len = 4'd10;
         default:                dec_len = 4'd1;
      endcase
      have_all  = (count >= CW'(dec_len));
      out_valid = 1'b0;
      out_err   = 2'd0;
      if (state == RUN) begin
         if (have_all) begin
            out_valid = 1'b1;
            out_err   = (icode >= 4'hC) ? 2'd1 : 2'd0;
         end else if (at_end) begin
            out_valid = 1'b1;
            out_err   = 2'd2;
         end
      end
      out_len   = dec_len;
      out_pc    = head_pc;
      halted    = (state == HALTED);
      out_instr = '0;
      for (int k = 0; k < 10; k++) begin
         out_instr[8*(9-k) +: 8] = (4'(k) < dec_len) ? win[k] : 8'h00;
      end
   end

   // Pop and fill sizing: a same-cycle pop frees room, and fill stops at the memory end or on redirect/halt/reset.
   always_comb begin
      pop        = out_valid & out_ready;
      pop_bytes  = have_all ? CW'(dec_len) : count;
      halt_pop   = pop && (out_err == 2'd0) && (icode == 4'h0);
      free_bytes = QB - 32'(count) + (pop ? 32'(pop_bytes) : 32'd0);
      fill_n     = FB;
      if (free_bytes < fill_n) begin
         fill_n = free_bytes;
      end
      if (at_end) begin
         fill_n = 0;
      end else if ((MEM_END - fetch_ptr) < 64'(fill_n)) begin
         fill_n = 32'(MEM_END - fetch_ptr);
      end
      if (!rst_n || redirect_valid || (state != RUN) || halt_pop) begin
         fill_n = 0;
      end
      for (int i = 0; i < FETCH_BYTES; i++) begin
         fill_byte[i] = mem[fetch_ptr[AW-1:0] + AW'(i)];
      end
   end

   // Queue storage: append the fetched bytes behind the current tail; contents need no reset because count guards them.
   always_ff @(posedge clk) begin
      for (int i = 0; i < FETCH_BYTES; i++) begin
         if (32'(i) < fill_n) begin
            qbuf[qidx(32'(head), 32'(count) + 32'(i))] <= fill_byte[i];
         end
      end
   end

   // Queue pointers and PCs: reset, then redirect, then the normal pop/fill bookkeeping while running.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count     <= '0;
         head      <= '0;
         fetch_ptr <= '0;
         head_pc   <= '0;
      end else if (redirect_valid) begin
         count     <= '0;
         head      <= '0;
         fetch_ptr <= redirect_pc;
         head_pc   <= redirect_pc;
      end else if (state == RUN) begin
         if (halt_pop) begin
            count   <= '0;
            head_pc <= head_pc + 64'(dec_len);
         end else begin
            if (pop) begin
               head    <= qidx(32'(head), 32'(pop_bytes));
               head_pc <= head_pc + 64'(dec_len);
            end
            count     <= count - (pop ? pop_bytes : '0) + CW'(fill_n);
            fetch_ptr <= fetch_ptr + 64'(fill_n);
         end
      end
   end

endmodule

// File: tb/tb_y86_fetch_queue.sv
// tb_y86_fetch_queue: directed program scenarios followed by randomized traffic,
// every cycle compared against a queue-based behavioural model of the fetch front end.
module tb_y86_fetch_queue;

   localparam int          MEM_BYTES   = 128;
   localparam int          FETCH_BYTES = 2;
   localparam int          QUEUE_BYTES = 16;
   localparam logic [63:0] MEM_END     = 64'(MEM_BYTES);

   logic        clk = 1'b0;
   logic        rst_n;
   logic        load_en;
   logic [63:0] load_addr;
   logic [7:0]  load_data;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [79:0] out_instr;
   logic [63:0] out_pc;
   logic [3:0]  out_len;
   logic [1:0]  out_err;
   logic        halted;

   int vectors     = 0;
   int miscompares = 0;

   logic [7:0]  img   [MEM_BYTES];
   logic [7:0]  mem_m [MEM_BYTES];
   logic [7:0]  mq [$];
   logic [63:0] m_fp;
   logic [63:0] m_hpc;
   bit          m_halt;

   bit          e_valid;
   logic [79:0] e_instr;
   int          e_len;
   int          e_err;
   logic [7:0]  e_b0;

   y86_fetch_queue #(
      .MEM_BYTES  (MEM_BYTES),
      .FETCH_BYTES(FETCH_BYTES),
      .QUEUE_BYTES(QUEUE_BYTES)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .load_en       (load_en),
      .load_addr     (load_addr),
      .load_data     (load_data),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_instr     (out_instr),
      .out_pc        (out_pc),
      .out_len       (out_len),
      .out_err       (out_err),
      .halted        (halted)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Instruction length straight from the Y86 icode table.
   function automatic int lenOf(input logic [3:0] ic);
      case (ic)
         4'h0, 4'h1, 4'h9:       return 1;
         4'h2, 4'h6, 4'hA, 4'hB: return 2;
         4'h7, 4'h8:             return 9;
         4'h3, 4'h4, 4'h5:       return 10;
         default:                return 1;
      endcase
   endfunction

   // Expected outputs from the model's current queue contents.
   function automatic void modelOutputs();
      e_b0    = (mq.size() > 0) ? mq[0] : 8'h00;
      e_len   = lenOf(e_b0[7:4]);
      e_instr = '0;
      for (int k = 0; k < e_len && k < mq.size(); k++) begin
         e_instr[8*(9-k) +: 8] = mq[k];
      end
      e_valid = 1'b0;
      e_err   = 0;
      if (!m_halt) begin
         if (mq.size() >= e_len) begin
            e_valid = 1'b1;
            e_err   = (e_b0[7:4] >= 4'hC) ? 1 : 0;
         end else if (m_fp >= MEM_END) begin
            e_valid = 1'b1;
            e_err   = 2;
         end
      end
   endfunction

   // Advance the model by one clock edge using the inputs currently driven.
   task automatic modelStep();
      bit pop;
      int n;
      modelOutputs();
      pop = e_valid && out_ready;
      if (!rst_n) begin
         mq.delete();
         m_fp   = '0;
         m_hpc  = '0;
         m_halt = 1'b0;
      end else if (redirect_valid) begin
         mq.delete();
         m_fp   = redirect_pc;
         m_hpc  = redirect_pc;
         m_halt = 1'b0;
      end else if (!m_halt) begin
         if (pop && e_err == 0 && e_b0[7:4] == 4'h0) begin
            m_halt = 1'b1;
            mq.delete();
            m_hpc += 64'(e_len);
         end else begin
            if (pop) begin
               for (int j = 0; j < e_len; j++) begin
                  if (mq.size() > 0) mq.delete(0);
               end
               m_hpc += 64'(e_len);
            end
            n = FETCH_BYTES;
            if (QUEUE_BYTES - mq.size() < n) n = QUEUE_BYTES - mq.size();
            if (m_fp >= MEM_END) n = 0;
            else if ((MEM_END - m_fp) < 64'(n)) n = int'(MEM_END - m_fp);
            for (int i = 0; i < n; i++) begin
               mq.push_back(mem_m[m_fp[6:0] + 7'(i)]);
            end
            m_fp += 64'(n);
         end
      end
      if (load_en && load_addr < MEM_END) begin
         mem_m[load_addr[6:0]] = load_data;
      end
   endtask

   // The one comparison point: counts the vector and reports any miscompare.
   task automatic checkOutput(input string tag, input logic [79:0] got, input logic [79:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h expected %h", tag, got, want);
      end
   endtask

   // Compare every DUT output against the model.
   task automatic compareAll();
      modelOutputs();
      checkOutput("out_valid", 80'(out_valid), 80'(e_valid));
      checkOutput("halted", 80'(halted), 80'(m_halt));
      checkOutput("out_pc", 80'(out_pc), 80'(m_hpc));
      if (e_valid) begin
         checkOutput("out_instr", out_instr, e_instr);
         checkOutput("out_len", 80'(out_len), 80'(e_len));
         checkOutput("out_err", 80'(out_err), 80'(e_err));
      end
   endtask

   // Drive one cycle of inputs, step the model at the edge and check just after it.
   task automatic applyStimulus(input logic r, input logic rdy, input logic rv, input logic [63:0] rpc,
                                input logic le, input logic [63:0] la, input logic [7:0] ld);
      rst_n          = r;
      out_ready      = rdy;
      redirect_valid = rv;
      redirect_pc    = rpc;
      load_en        = le;
      load_addr      = la;
      load_data      = ld;
      @(posedge clk);
      modelStep();
      #1;
      compareAll();
   endtask

   // Place up to ten bytes (byte0 in the top of val) into the program image.
   function automatic void setBytes(input int base, input logic [79:0] val, input int len);
      for (int k = 0; k < len; k++) begin
         img[base + k] = val[8*(9-k) +: 8];
      end
   endfunction

   // Test sequence: directed program scenarios then randomized traffic.
   initial begin
      int          cyc;
      logic [63:0] pcs [$];
      logic [63:0] exp_pcs [6];
      int          r;

      for (int a = 0; a < MEM_BYTES; a++) begin
         img[a]   = 8'h00;
         mem_m[a] = 8'h00;
      end
      setBytes(0,  80'h30F3_0000_0000_0000_0008, 10);
      setBytes(10, 80'h30F2_0000_0000_0000_0002, 10);
      setBytes(20, {16'h6023, 64'h0}, 2);
      setBytes(22, 80'h4020_0000_0000_0000_0008, 10);
      setBytes(32, {16'hA020, 64'h0}, 2);
      setBytes(48, 80'h50C0_0000_0000_0000_0008, 10);
      img[MEM_BYTES-2] = 8'h30;
      exp_pcs = '{64'd0, 64'd10, 64'd20, 64'd22, 64'd32, 64'd34};
      mq.delete();
      m_fp   = '0;
      m_hpc  = '0;
      m_halt = 1'b0;

      // Program loaded while reset is held.
      for (int a = 0; a < MEM_BYTES; a++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, 64'd0, 1'b1, 64'(a), img[a]);
      end
      checkOutput("rst_instr", out_instr, 80'd0);
      checkOutput("rst_len", 80'(out_len), 80'd1);
      checkOutput("rst_err", 80'(out_err), 80'd0);

      // First 10-byte instruction latency, then the in-order stream up to HALT.
      applyStimulus(1'b1, 1'b1, 1'b0, 64'd0, 1'b0, 64'd0, 8'h00);
      cyc = 1;
      while (!out_valid && cyc < 20) begin
         applyStimulus(1'b1, 1'b1, 1'b0, 64'd0, 1'b0, 64'd0, 8'h00);
         cyc++;
      end
      checkOutput("first_latency", 80'(cyc), 80'd5);
      checkOutput("first_instr", out_instr, 80'h30F3_0000_0000_0000_0008);
      for (int t = 0; t < 80 && !halted; t++) begin
         if (out_valid) pcs.push_back(out_pc);
         applyStimulus(1'b1, 1'b1, 1'b0, 64'd0, 1'b0, 64'd0, 8'h00);
      end
      checkOutput("halt_after_prog", 80'(halted), 80'd1);
      checkOutput("pop_count", 80'(pcs.size()), 80'd6);
      for (int i = 0; i < 6 && i < pcs.size(); i++) begin
         checkOutput("pop_pc", 80'(pcs[i]), 80'(exp_pcs[i]));
      end

      // Backpressure on the first instruction, then drain.
      applyStimulus(1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0, 8'h00);
      for (int t = 0; t < 14; t++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0, 8'h00);
      end
      for (int t = 0; t < 60 && !halted; t++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, 64'd0, 1'b0, 64'd0, 8'h00);
      end
      checkOutput("halt_after_bp", 80'(halted), 80'd1);

      // Redirect colliding with the pop of the addq at pc 20.
      applyStimulus(1'b0, 1'b1, 1'b0, 64'd0, 1'b0, 64'd0, 8'h00);
      cyc = 0;
      while (!(out_valid && out_pc == 64'd20) && cyc < 40) begin
         applyStimulus(1'b1, 1'b1, 1'b0, 64'd0, 1'b0, 64'd0, 8'h00);
         cyc++;
      end
      checkOutput("reach_pc20", 80'(out_pc), 80'd20);
      applyStimulus(1'b1, 1'b1, 1'b1, 64'd48, 1'b0, 64'd0, 8'h00);
      cyc = 0;
      while (!out_valid && cyc < 12) begin
         applyStimulus(1'b1, 1'b1, 1'b0, 64'd0, 1'b0, 64'd0, 8'h00);
         cyc++;
      end
      checkOutput("redir_pc", 80'(out_pc), 80'd48);
      checkOutput("redir_len", 80'(out_len), 80'd10);
      checkOutput("redir_byte0", 80'(out_instr[79:72]), 80'h50);

      // Invalid icode at address 0.
      applyStimulus(1'b0, 1'b0, 1'b0, 64'd0, 1'b1, 64'd0, 8'hF0);
      applyStimulus(1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0, 8'h00);
      checkOutput("ins_valid", 80'(out_valid), 80'd1);
      checkOutput("ins_err", 80'(out_err), 80'd1);
      checkOutput("ins_len", 80'(out_len), 80'd1);
      applyStimulus(1'b1, 1'b1, 1'b0, 64'd0, 1'b0, 64'd0, 8'h00);
      checkOutput("ins_next_pc", 80'(out_pc), 80'd1);

      // Truncated instruction at the end of memory, then a redirect past it.
      applyStimulus(1'b1, 1'b0, 1'b1, MEM_END - 64'd2, 1'b0, 64'd0, 8'h00);
      applyStimulus(1'b1, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0, 8'h00);
      checkOutput("adr_err", 80'(out_err), 80'd2);
      checkOutput("adr_len", 80'(out_len), 80'd10);
      checkOutput("adr_pc", 80'(out_pc), 80'(MEM_END - 64'd2));
      checkOutput("adr_instr", out_instr, {8'h30, 72'h0});
      applyStimulus(1'b1, 1'b0, 1'b1, MEM_END + 64'd5, 1'b0, 64'd0, 8'h00);
      checkOutput("far_valid", 80'(out_valid), 80'd1);
      checkOutput("far_err", 80'(out_err), 80'd2);
      checkOutput("far_len", 80'(out_len), 80'd1);
      checkOutput("far_instr", out_instr, 80'd0);
      checkOutput("far_pc", 80'(out_pc), 80'(MEM_END + 64'd5));

      // Reset in the middle of a 10-byte fill; program re-runs from 0.
      applyStimulus(1'b0, 1'b1, 1'b0, 64'd0, 1'b1, 64'd0, 8'h30);
      for (int t = 0; t < 3; t++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, 64'd0, 1'b0, 64'd0, 8'h00);
      end
      applyStimulus(1'b0, 1'b1, 1'b0, 64'd0, 1'b0, 64'd0, 8'h00);
      checkOutput("midrst_valid", 80'(out_valid), 80'd0);
      checkOutput("midrst_pc", 80'(out_pc), 80'd0);
      checkOutput("midrst_halted", 80'(halted), 80'd0);
      for (int t = 0; t < 80 && !halted; t++) begin
         applyStimulus(1'b1, 1'b1, 1'b0, 64'd0, 1'b0, 64'd0, 8'h00);
      end
      checkOutput("rerun_halt", 80'(halted), 80'd1);

      // Randomized traffic: random memory, backpressure, redirects, resets and loads.
      for (int a = 0; a < MEM_BYTES; a++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, 64'd0, 1'b1, 64'(a), 8'($urandom));
      end
      for (int t = 0; t < 2500; t++) begin
         logic [63:0] rpc;
         r   = $urandom_range(0, 99);
         rpc = ($urandom_range(0, 7) == 0) ? {$urandom, $urandom}
                                           : 64'($urandom_range(0, MEM_BYTES + 4));
         applyStimulus(r != 0, $urandom_range(0, 3) != 0, (r >= 1 && r <= 4), rpc,
                       $urandom_range(0, 4) == 0, 64'($urandom_range(0, MEM_BYTES + 3)),
                       8'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
